ultrasonic_scan_sched: RTL and testbench
========================================

Name: ultrasonic_scan_sched

Overview:
Round-robin scheduler that shares one trigger/echo measurement engine between NUM_CH ultrasonic sensors.
- For each enabled channel, in turn: warmup, trigger pulse, wait for echo rising edge, count echo-high cycles, report the result, then hold a guard gap before the next channel.
- Sits between the sensor pins and the distance/obstacle logic, which consumes one result per channel per scan.

Parameters:
NUM_CH, 4, number of sensor channels (2..8)
CNT_W, 22, width of cycle counters and the pulse-count result
WARMUP_CYC, 50, cycles held in WARMUP before triggering (1 us at 50 MHz)
TRIG_CYC, 500, trigger high time in cycles (10 us)
RISE_TMO_CYC, 50000, maximum wait for echo rising edge (1 ms)
ECHO_MAX_CYC, 1250000, saturation limit for echo-high count (25 ms)
GUARD_CYC, 3000000, gap after each report before the next channel (60 ms)

Ports:
clk_50M  in  1  system clock, 50 MHz
reset  in  1  asynchronous active-low reset
run  in  1  level; 1 = keep scanning, 0 = stop after the current channel completes
ch_en  in  NUM_CH  channel enable mask, sampled at each channel selection
echo_rx  in  NUM_CH  raw asynchronous echo inputs
trigger  out  NUM_CH  one-hot trigger; only the active channel's bit can be 1
res_valid  out  1  one-cycle strobe, result fields valid
res_ch  out  $clog2(NUM_CH)  channel of the result
res_pulses  out  CNT_W  echo-high cycle count; 0 on rise timeout
res_timeout  out  1  1 = no echo rise seen, or echo saturated at ECHO_MAX_CYC
busy  out  1  1 in every state except IDLE
state  out  3  current FSM state, for debug

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. trigger, res_valid, res_ch, res_pulses, res_timeout, busy all 0. Counters 0. Round-robin pointer = NUM_CH-1, so the first channel selected is 0. Synchronizer flops 0.
- Echo input: each echo_rx bit passes through a 2-flop synchronizer. All FSM decisions use the synchronized value, which lags the pin by 2 cycles.
- FSM encoding: IDLE=0, SELECT=1, WARMUP=2, TRIGGER=3, WAIT_RISE=4, MEASURE=5, REPORT=6, GUARD=7.
- IDLE -> SELECT when run=1 and ch_en!=0. Otherwise stay in IDLE.
- SELECT (1 cycle): pick the next enabled channel after the pointer, wrapping modulo NUM_CH, and latch it as cur_ch.
  - If only the pointer's own channel is enabled, reselect it.
  - If ch_en=0 at this point, go to IDLE.
  - Otherwise go to WARMUP with the counter cleared.
- WARMUP: WARMUP_CYC cycles, then TRIGGER.
- TRIGGER: trigger[cur_ch]=1 for exactly TRIG_CYC cycles. Then clear trigger and go to WAIT_RISE.
- WAIT_RISE:
  - Synchronized echo of cur_ch = 1 -> MEASURE, with the count set to 1.
  - After RISE_TMO_CYC cycles with no rise -> REPORT with pulses=0 and timeout=1.
  - An echo already high on entry counts as the rise.
- MEASURE:
  - Count +1 per cycle while the echo is high.
  - Echo low -> REPORT with timeout=0.
  - Count reaching ECHO_MAX_CYC -> REPORT with pulses=ECHO_MAX_CYC and timeout=1.
  - The count never wraps.
- REPORT (1 cycle): res_valid=1; res_ch=cur_ch; res_pulses and res_timeout take the captured values. The pointer is set to cur_ch. res_ch, res_pulses and res_timeout hold until the next REPORT. Then GUARD.
- GUARD: GUARD_CYC cycles with all trigger bits 0. Then SELECT if run=1 and ch_en!=0, else IDLE.
- run=0 mid-channel: the sequence completes through REPORT and GUARD, then goes to IDLE. No result is dropped.
- ch_en changing mid-channel: has no effect until the next SELECT. A disabled cur_ch still finishes.
- Echo activity on non-selected channels is ignored.
- Reset asserted mid-operation: immediate return to reset values; trigger drops asynchronously.
- Width: all counters are CNT_W bits. ECHO_MAX_CYC, RISE_TMO_CYC and GUARD_CYC must be < 2^CNT_W. The implementation enforces this with an elaboration check.

Decomposition:
- Shared package ultrasonic_pkg holds:
  - the state encodings;
  - the default timing constants (WARMUP, TRIG, RISE_TMO, ECHO_MAX, GUARD) expressed at 50 MHz;
  - a clog2 function.
- One sub-module, echo_sync2: a parameterised-width 2-flop synchronizer with async active-low reset, instantiated once with width NUM_CH.
- Round-robin selection stays inline as a combinational function.

Test Plan:
All scenarios use small parameters: WARMUP_CYC=4, TRIG_CYC=10, RISE_TMO_CYC=50, ECHO_MAX_CYC=200, GUARD_CYC=20.
- Basic: ch_en=4'b0001, run=1, echo[0] pulse high for 37 cycles starting 5 cycles after trigger falls -> trigger[0] high exactly 10 cycles; res_valid with res_ch=0, res_pulses=37, res_timeout=0.
- Round-robin: ch_en=4'b1011, each echo 20 cycles -> results in order ch 0,1,3,0; trigger[2] never asserts; 20 idle cycles between the REPORT strobe and the next WARMUP entry.
- Rise timeout: no echo on ch 1 -> res_pulses=0, res_timeout=1 exactly 50 cycles after entering WAIT_RISE; the scheduler proceeds to the next channel.
- Saturation: echo[0] held high -> res_pulses=200, res_timeout=1; the next channel starts after GUARD.
- Stop and mask: run dropped during MEASURE of ch 2 -> the ch 2 result is still reported, then IDLE with busy=0. Setting ch_en=0 during GUARD -> IDLE after GUARD.
- Async reset: reset=0 during TRIGGER -> trigger=0 and state=IDLE with no clock edge; after release with run=1, the first channel selected is 0.

Source files
------------

// File: rtl/ultrasonic_scan_sched_pkg.sv
// Shared state encodings, 50 MHz default timing constants and a clog2 helper
// for the ultrasonic scan scheduler.
package ultrasonic_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SELECT    = 3'd1,
      S_WARMUP    = 3'd2,
      S_TRIGGER   = 3'd3,
      S_WAIT_RISE = 3'd4,
      S_MEASURE   = 3'd5,
      S_REPORT    = 3'd6,
      S_GUARD     = 3'd7
   } state_t;

   localparam int DEF_NUM_CH       = 4;
   localparam int DEF_CNT_W        = 22;
   localparam int DEF_WARMUP_CYC   = 50;
   localparam int DEF_TRIG_CYC     = 500;
   localparam int DEF_RISE_TMO_CYC = 50000;
   localparam int DEF_ECHO_MAX_CYC = 1250000;
   localparam int DEF_GUARD_CYC    = 3000000;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ultrasonic_scan_sched_if.sv
// Sensor-side and result-side signals of the scan scheduler; the scheduler
// uses the slave modport, the sensor/consumer side uses master.
interface ultrasonic_scan_sched_if
   import ultrasonic_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CNT_W  = DEF_CNT_W
);
   localparam int CH_W = clog2(NUM_CH);

   logic              run;
   logic [NUM_CH-1:0] ch_en;
   logic [NUM_CH-1:0] echo_rx;
   logic [NUM_CH-1:0] trigger;
   logic              res_valid;
   logic [CH_W-1:0]   res_ch;
   logic [CNT_W-1:0]  res_pulses;
   logic              res_timeout;
   logic              busy;
   logic [2:0]        state;

   modport slave (
      input  run, ch_en, echo_rx,
      output trigger, res_valid, res_ch, res_pulses, res_timeout, busy, state
   );

   modport master (
      output run, ch_en, echo_rx,
      input  trigger, res_valid, res_ch, res_pulses, res_timeout, busy, state
   );

endinterface

// File: rtl/ultrasonic_scan_sched_echo_sync2.sv
// Two-flop synchronizer for the asynchronous echo pins; output lags the pin
// by two clock cycles.
module echo_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/ultrasonic_scan_sched.sv
// Round-robin scheduler sharing one trigger/echo measurement engine between
// NUM_CH ultrasonic sensors; one result per enabled channel per scan.
module ultrasonic_scan_sched
   import ultrasonic_pkg::*;
#(
   parameter int NUM_CH       = DEF_NUM_CH,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int WARMUP_CYC   = DEF_WARMUP_CYC,
   parameter int TRIG_CYC     = DEF_TRIG_CYC,
   parameter int RISE_TMO_CYC = DEF_RISE_TMO_CYC,
   parameter int ECHO_MAX_CYC = DEF_ECHO_MAX_CYC,
   parameter int GUARD_CYC    = DEF_GUARD_CYC
) (
   input  logic clk_50M,
   input  logic reset,
   ultrasonic_scan_sched_if.slave bus
);

   localparam int     CH_W    = clog2(NUM_CH);
   localparam longint CNT_LIM = longint'(1) << CNT_W;

   if (longint'(ECHO_MAX_CYC) >= CNT_LIM || longint'(RISE_TMO_CYC) >= CNT_LIM ||
       longint'(GUARD_CYC) >= CNT_LIM || longint'(WARMUP_CYC) >= CNT_LIM ||
       longint'(TRIG_CYC) >= CNT_LIM) begin : g_bad_cnt_w
      $error("ultrasonic_scan_sched: timing constant does not fit in CNT_W bits");
   end
   if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
      $error("ultrasonic_scan_sched: NUM_CH must be 2..8");
   end

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [CH_W-1:0]   r_cur_ch, w_cur_ch_nxt;
   logic [CH_W-1:0]   r_ptr, w_ptr_nxt;
   logic [NUM_CH-1:0] r_trigger, w_trigger_nxt;
   logic              r_res_valid, w_res_valid_nxt;
   logic [CH_W-1:0]   r_res_ch, w_res_ch_nxt;
   logic [CNT_W-1:0]  r_res_pulses, w_res_pulses_nxt;
   logic              r_res_timeout, w_res_timeout_nxt;
   logic [NUM_CH-1:0] w_echo_s;
   logic              w_echo_cur;
   logic              w_go;

   echo_sync2 #(.WIDTH(NUM_CH)) u_echo_sync (
      .i_clk   (clk_50M),
      .i_rst_n (reset),
      .i_d     (bus.echo_rx),
      .o_q     (w_echo_s)
   );

   // First enabled channel strictly after ptr; ptr itself is tried last.
   function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] ptr,
                                                input logic [NUM_CH-1:0] en);
      logic [CH_W-1:0] sel;
      logic            found;
      int              idx;
      sel   = ptr;
      found = 1'b0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = (int'(ptr) + i) % NUM_CH;
         if (!found && en[idx]) begin
            sel   = CH_W'(idx);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   assign w_echo_cur = w_echo_s[r_cur_ch];
   assign w_go       = bus.run && (bus.ch_en != '0);

   always_comb begin
      w_state_nxt       = r_state;
      w_cnt_nxt         = r_cnt;
      w_cur_ch_nxt      = r_cur_ch;
      w_ptr_nxt         = r_ptr;
      w_trigger_nxt     = r_trigger;
      w_res_valid_nxt   = 1'b0;
      w_res_ch_nxt      = r_res_ch;
      w_res_pulses_nxt  = r_res_pulses;
      w_res_timeout_nxt = r_res_timeout;
      case (r_state)
         S_IDLE: begin
            if (w_go) w_state_nxt = S_SELECT;
         end
         S_SELECT: begin
            if (bus.ch_en == '0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cur_ch_nxt = rr_next(r_ptr, bus.ch_en);
               w_cnt_nxt    = '0;
               w_state_nxt  = S_WARMUP;
            end
         end
         S_WARMUP: begin
            if (r_cnt == CNT_W'(WARMUP_CYC - 1)) begin
               w_cnt_nxt     = '0;
               w_trigger_nxt = NUM_CH'(1) << r_cur_ch;
               w_state_nxt   = S_TRIGGER;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_TRIGGER: begin
            if (r_cnt == CNT_W'(TRIG_CYC - 1)) begin
               w_cnt_nxt     = '0;
               w_trigger_nxt = '0;
               w_state_nxt   = S_WAIT_RISE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_WAIT_RISE: begin
            if (w_echo_cur) begin
               w_cnt_nxt   = CNT_W'(1);
               w_state_nxt = S_MEASURE;
            end else if (r_cnt == CNT_W'(RISE_TMO_CYC - 1)) begin
               w_cnt_nxt         = '0;
               w_res_valid_nxt   = 1'b1;
               w_res_ch_nxt      = r_cur_ch;
               w_res_pulses_nxt  = '0;
               w_res_timeout_nxt = 1'b1;
               w_state_nxt       = S_REPORT;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_MEASURE: begin
            // Result registers load on entry to REPORT so res_valid lines up with it.
            if (!w_echo_cur) begin
               w_cnt_nxt         = '0;
               w_res_valid_nxt   = 1'b1;
               w_res_ch_nxt      = r_cur_ch;
               w_res_pulses_nxt  = r_cnt;
               w_res_timeout_nxt = 1'b0;
               w_state_nxt       = S_REPORT;
            end else if (r_cnt == CNT_W'(ECHO_MAX_CYC - 1)) begin
               w_cnt_nxt         = '0;
               w_res_valid_nxt   = 1'b1;
               w_res_ch_nxt      = r_cur_ch;
               w_res_pulses_nxt  = CNT_W'(ECHO_MAX_CYC);
               w_res_timeout_nxt = 1'b1;
               w_state_nxt       = S_REPORT;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_REPORT: begin
            w_ptr_nxt   = r_cur_ch;
            w_cnt_nxt   = '0;
            w_state_nxt = S_GUARD;
         end
         S_GUARD: begin
            if (r_cnt == CNT_W'(GUARD_CYC - 1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = w_go ? S_SELECT : S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_50M or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_cur_ch      <= '0;
         r_ptr         <= CH_W'(NUM_CH - 1);
         r_trigger     <= '0;
         r_res_valid   <= 1'b0;
         r_res_ch      <= '0;
         r_res_pulses  <= '0;
         r_res_timeout <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_cur_ch      <= w_cur_ch_nxt;
         r_ptr         <= w_ptr_nxt;
         r_trigger     <= w_trigger_nxt;
         r_res_valid   <= w_res_valid_nxt;
         r_res_ch      <= w_res_ch_nxt;
         r_res_pulses  <= w_res_pulses_nxt;
         r_res_timeout <= w_res_timeout_nxt;
      end
   end

   assign bus.trigger     = r_trigger;
   assign bus.res_valid   = r_res_valid;
   assign bus.res_ch      = r_res_ch;
   assign bus.res_pulses  = r_res_pulses;
   assign bus.res_timeout = r_res_timeout;
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.state       = r_state;

endmodule

// File: tb/tb_ultrasonic_scan_sched.sv
// Directed bench for ultrasonic_scan_sched with small timing constants;
// a responder drives echoes a fixed delay after each trigger falls.
module tb_ultrasonic_scan_sched;
   import ultrasonic_pkg::*;

   localparam int NCH = 4;
   localparam int NV  = 10;

   logic clk_50M;
   logic reset;

   ultrasonic_scan_sched_if #(.NUM_CH(NCH), .CNT_W(22)) bus ();

   ultrasonic_scan_sched #(
      .NUM_CH(NCH), .CNT_W(22), .WARMUP_CYC(4), .TRIG_CYC(10),
      .RISE_TMO_CYC(50), .ECHO_MAX_CYC(200), .GUARD_CYC(20)
   ) dut (
      .clk_50M (clk_50M),
      .reset   (reset),
      .bus     (bus)
   );

   initial clk_50M = 1'b0;
   always #10 clk_50M = ~clk_50M;

   typedef struct { int ch; int pulses; int to; int wrlat; } res_t;
   typedef struct {
      bit new_scn; logic [3:0] en; int l0; int l1; int l2; int l3;
      int ech; int epulses; int eto; int ewrlat;
   } vec_t;

   int   n_vec = 0;
   int   n_fail = 0;
   int   lens [NCH];
   res_t res_q [64];
   int   res_n, rd_idx;
   int   onehot_err, trig_bad, trig_runs, guard_bad, guard_n;
   int   trig_cnt [NCH];
   int   cyc, wr_entry, run_len, gcnt;
   logic [2:0] prev_state;

   // Echo responder: pulse of lens[k] cycles starting 5 cycles after trigger[k] falls.
   initial begin
      int dly [NCH];
      int hi [NCH];
      logic [NCH-1:0] ptrig;
      bus.echo_rx = '0;
      ptrig = '0;
      for (int k = 0; k < NCH; k++) begin dly[k] = 0; hi[k] = 0; end
      forever begin
         @(negedge clk_50M);
         if (!reset) begin
            bus.echo_rx = '0;
            ptrig = '0;
            for (int k = 0; k < NCH; k++) begin dly[k] = 0; hi[k] = 0; end
         end else begin
            for (int k = 0; k < NCH; k++) begin
               if (dly[k] > 0) begin
                  dly[k]--;
                  if (dly[k] == 0) begin bus.echo_rx[k] = 1'b1; hi[k] = lens[k]; end
               end else if (hi[k] > 0) begin
                  hi[k]--;
                  if (hi[k] == 0) bus.echo_rx[k] = 1'b0;
               end
               if (ptrig[k] && !bus.trigger[k] && lens[k] > 0) dly[k] = 5;
            end
            ptrig = bus.trigger;
         end
      end
   end

   // Monitor: result capture plus trigger/guard timing statistics.
   initial begin
      cyc = 0; res_n = 0; prev_state = 3'd0;
      forever begin
         @(negedge clk_50M);
         cyc++;
         if (!reset) begin
            res_n = 0; onehot_err = 0; trig_bad = 0; trig_runs = 0;
            guard_bad = 0; guard_n = 0; run_len = 0; gcnt = 0; wr_entry = 0;
            for (int k = 0; k < NCH; k++) trig_cnt[k] = 0;
            prev_state = 3'd0;
         end else begin
            if (!$onehot0(bus.trigger)) onehot_err++;
            for (int k = 0; k < NCH; k++) if (bus.trigger[k]) trig_cnt[k]++;
            if (|bus.trigger) run_len++;
            else if (run_len > 0) begin
               trig_runs++;
               if (run_len != 10) trig_bad++;
               run_len = 0;
            end
            if (bus.state == S_GUARD) gcnt++;
            else if (prev_state == S_GUARD) begin
               guard_n++;
               if (gcnt != 20) guard_bad++;
               gcnt = 0;
            end
            if (bus.state == S_WAIT_RISE && prev_state != S_WAIT_RISE) wr_entry = cyc;
            if (bus.res_valid && res_n < 64) begin
               res_q[res_n] = '{int'(bus.res_ch), int'(bus.res_pulses),
                                int'(bus.res_timeout), cyc - wr_entry};
               res_n++;
            end
            prev_state = bus.state;
         end
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset(input logic [3:0] en, input int l0, input int l1,
                           input int l2, input int l3);
      reset = 1'b0;
      bus.run = 1'b0;
      bus.ch_en = en;
      lens[0] = l0; lens[1] = l1; lens[2] = l2; lens[3] = l3;
      repeat (2) @(negedge clk_50M);
      #5 reset = 1'b1;
      rd_idx = 0;
      @(negedge clk_50M);
      bus.run = 1'b1;
   endtask

   task automatic wait_result(output res_t r, output bit ok);
      ok = 1'b0;
      r = '{default: 0};
      for (int n = 0; n < 3000 && !ok; n++) begin
         @(posedge clk_50M);
         if (res_n > rd_idx) begin
            r = res_q[rd_idx];
            rd_idx++;
            ok = 1'b1;
         end
      end
   endtask

   task automatic wait_state(input logic [2:0] target, input int bound,
                             output bit ok, output int n);
      ok = 1'b0;
      n = 0;
      while (!ok && n < bound) begin
         @(negedge clk_50M);
         n++;
         if (bus.state == target) ok = 1'b1;
      end
   endtask

   task automatic scenario_checks(input logic [3:0] en);
      int masked;
      masked = 0;
      for (int k = 0; k < NCH; k++) if (!en[k]) masked += trig_cnt[k];
      chk("onehot_trigger", onehot_err, 0);
      chk("trigger_width_bad", trig_bad, 0);
      chk("trigger_seen", (trig_runs > 0) ? 1 : 0, 1);
      chk("guard_len_bad", guard_bad, 0);
      chk("masked_trigger_cycles", masked, 0);
   endtask

   initial begin
      vec_t tv [NV];
      res_t r;
      bit ok;
      int n;
      logic [3:0] scn_en;

      tv[0] = '{1'b1, 4'b0001, 37, 0, 0, 0, 0, 37, 0, -1};
      tv[1] = '{1'b1, 4'b1011, 20, 20, 20, 20, 0, 20, 0, -1};
      tv[2] = '{1'b0, 4'b1011, 20, 20, 20, 20, 1, 20, 0, -1};
      tv[3] = '{1'b0, 4'b1011, 20, 20, 20, 20, 3, 20, 0, -1};
      tv[4] = '{1'b0, 4'b1011, 20, 20, 20, 20, 0, 20, 0, -1};
      tv[5] = '{1'b1, 4'b0011, 15, 0, 0, 0, 0, 15, 0, -1};
      tv[6] = '{1'b0, 4'b0011, 15, 0, 0, 0, 1, 0, 1, 50};
      tv[7] = '{1'b0, 4'b0011, 15, 0, 0, 0, 0, 15, 0, -1};
      tv[8] = '{1'b1, 4'b0011, 300, 25, 0, 0, 0, 200, 1, -1};
      tv[9] = '{1'b0, 4'b0011, 300, 25, 0, 0, 1, 25, 0, -1};

      reset = 1'b0;
      bus.run = 1'b0;
      bus.ch_en = '0;
      for (int k = 0; k < NCH; k++) lens[k] = 0;
      rd_idx = 0;
      scn_en = '0;
      repeat (2) @(negedge clk_50M);
      chk("reset_state", bus.state, 0);
      chk("reset_busy", bus.busy, 0);
      chk("reset_trigger", bus.trigger, 0);
      chk("reset_res_valid", bus.res_valid, 0);
      chk("reset_res_ch", bus.res_ch, 0);
      chk("reset_res_pulses", bus.res_pulses, 0);
      chk("reset_res_timeout", bus.res_timeout, 0);

      for (int i = 0; i < NV; i++) begin
         if (tv[i].new_scn) begin
            scn_en = tv[i].en;
            do_reset(tv[i].en, tv[i].l0, tv[i].l1, tv[i].l2, tv[i].l3);
         end
         wait_result(r, ok);
         chk($sformatf("v%0d_result_arrived", i), ok, 1);
         if (ok) begin
            chk($sformatf("v%0d_res_ch", i), r.ch, tv[i].ech);
            chk($sformatf("v%0d_res_pulses", i), r.pulses, tv[i].epulses);
            chk($sformatf("v%0d_res_timeout", i), r.to, tv[i].eto);
            if (tv[i].ewrlat >= 0) chk($sformatf("v%0d_rise_tmo_lat", i), r.wrlat, tv[i].ewrlat);
         end
         if (i == NV - 1) scenario_checks(scn_en);
         else if (tv[i + 1].new_scn) scenario_checks(scn_en);
      end

      // run dropped during MEASURE of ch 2: result still reported, then IDLE.
      do_reset(4'b0100, 0, 0, 40, 0);
      wait_state(S_MEASURE, 500, ok, n);
      chk("stop_reach_measure", ok, 1);
      bus.run = 1'b0;
      wait_result(r, ok);
      chk("stop_result_arrived", ok, 1);
      chk("stop_res_ch", r.ch, 2);
      chk("stop_res_pulses", r.pulses, 40);
      chk("stop_res_timeout", r.to, 0);
      wait_state(S_IDLE, 100, ok, n);
      chk("stop_reach_idle", ok, 1);
      chk("stop_busy", bus.busy, 0);
      repeat (30) @(negedge clk_50M);
      chk("stop_stays_idle", bus.state, 0);
      chk("stop_guard_count", guard_n, 1);

      // ch_en cleared during GUARD: IDLE right after the 20 guard cycles.
      lens[0] = 10;
      bus.ch_en = 4'b0001;
      bus.run = 1'b1;
      wait_state(S_GUARD, 500, ok, n);
      chk("mask_reach_guard", ok, 1);
      bus.ch_en = 4'b0000;
      wait_state(S_IDLE, 40, ok, n);
      chk("mask_reach_idle", ok, 1);
      chk("mask_idle_latency", n, 20);
      repeat (30) @(negedge clk_50M);
      chk("mask_stays_idle", bus.state, 0);

      // Async reset during TRIGGER of ch 1; afterwards scanning restarts at ch 0.
      do_reset(4'b0011, 12, 12, 0, 0);
      wait_result(r, ok);
      chk("arst_first_ch", r.ch, 0);
      wait_state(S_TRIGGER, 300, ok, n);
      chk("arst_reach_trigger", ok, 1);
      chk("arst_pre_trigger", bus.trigger, 4'b0010);
      #3 reset = 1'b0;
      #1;
      chk("arst_trigger_async", bus.trigger, 0);
      chk("arst_state_async", bus.state, 0);
      chk("arst_busy_async", bus.busy, 0);
      repeat (2) @(negedge clk_50M);
      #5 reset = 1'b1;
      rd_idx = 0;
      wait_result(r, ok);
      chk("arst_restart_arrived", ok, 1);
      chk("arst_restart_ch", r.ch, 0);
      chk("arst_restart_pulses", r.pulses, 12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
